// File: rtl/nr_divider_param.sv
// Iterative non-restoring integer divider with run-time signed/unsigned mode.
// Start/Busy/Done handshake; divide-by-zero and signed-overflow flags per result.
module nr_divider_param #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic [WIDTH-1:0] Out_Q,
  output logic [WIDTH-1:0] Out_R,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, CORR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic [WIDTH-1:0] out_r_q, out_r_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             mode;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   b_ext;
  logic [2*WIDTH:0] pa_sh;
  logic [WIDTH:0]   p_iter;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] r_mag;

  always_comb begin
    mode   = Signed_Mode & SIGNED_EN;
    sign_a = mode & InA[WIDTH-1];
    sign_b = mode & InB[WIDTH-1];
    mag_a  = sign_a ? -InA : InA;
    mag_b  = sign_b ? -InB : InB;

    // {P,A} shifted together; P is allowed to wrap, the +/-B step brings it back in range
    b_ext  = {1'b0, b_q};
    pa_sh  = {p_q, a_q} << 1;
    p_iter = p_q[WIDTH] ? (pa_sh[2*WIDTH:WIDTH] + b_ext) : (pa_sh[2*WIDTH:WIDTH] - b_ext);
    p_fix  = p_q[WIDTH] ? (p_q + b_ext) : p_q;
    r_mag  = p_fix[WIDTH-1:0];

    state_d    = state_q;
    p_d        = p_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    dbz_pend_d = dbz_pend_q;
    ovf_pend_d = ovf_pend_q;
    out_q_d    = out_q_q;
    out_r_d    = out_r_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (Start) begin
          dbz_d      = 1'b0;
          ovf_d      = 1'b0;
          p_d        = '0;
          b_d        = mag_b;
          cnt_d      = '0;
          qneg_d     = sign_a ^ sign_b;
          rneg_d     = sign_a;
          dbz_pend_d = (InB == '0);
          ovf_pend_d = mode && (InA == {1'b1, {(WIDTH-1){1'b0}}}) && (InB == '1);
          if (InB == '0) begin
            // raw dividend kept so the remainder can be returned unmodified
            a_d     = InA;
            state_d = CORR;
          end else begin
            a_d     = mag_a;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        p_d   = p_iter;
        a_d   = {pa_sh[WIDTH-1:1], ~p_iter[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = CORR;
        end
      end
      CORR: begin
        if (dbz_pend_q) begin
          out_q_d = '1;
          out_r_d = a_q;
        end else begin
          out_q_d = qneg_q ? -a_q : a_q;
          out_r_d = rneg_q ? -r_mag : r_mag;
        end
        dbz_d   = dbz_pend_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      p_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_q_q    <= '0;
      out_r_q    <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      dbz_pend_q <= dbz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      out_q_q    <= out_q_d;
      out_r_q    <= out_r_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign Out_Q       = out_q_q;
  assign Out_R       = out_r_q;
  assign Div_By_Zero = dbz_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_nr_divider_param.sv
// Scoreboard bench for nr_divider_param: 8-bit signed-capable and 16-bit unsigned-only instances.
module tb_nr_divider_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8, sm8;
  logic [7:0] a8, b8, q8, r8;
  logic       busy8, done8, dbz8, ovf8;
  logic        s16, sm16;
  logic [15:0] a16, b16, q16, r16;
  logic        busy16, done16, dbz16, ovf16;

  int checks   = 0;
  int failures = 0;

  typedef struct {logic [7:0] q; logic [7:0] r; logic dbz; logic ovf;} exp8_t;
  typedef struct {logic [15:0] q; logic [15:0] r;} exp16_t;
  exp8_t  sb8[$];
  exp16_t sb16[$];

  nr_divider_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .Start(s8), .Signed_Mode(sm8), .InA(a8), .InB(b8),
    .Out_Q(q8), .Out_R(r8), .Busy(busy8), .Done(done8),
    .Div_By_Zero(dbz8), .Overflow(ovf8)
  );

  nr_divider_param #(.WIDTH(16), .SIGNED_EN(1'b0)) u16 (
    .clk(clk), .rst(rst), .Start(s16), .Signed_Mode(sm16), .InA(a16), .InB(b16),
    .Out_Q(q16), .Out_R(r16), .Busy(busy16), .Done(done16),
    .Div_By_Zero(dbz16), .Overflow(ovf16)
  );

  // Drive one request on the 8-bit unit and record what it must return.
  task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input logic eovf);
    exp8_t e;
    e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
    sb8.push_back(e);
    s8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    s8 = 1'b0;
  endtask

  // Wait (bounded) for Done; returns cycles since the Start edge and Busy-high cycles.
  task automatic wait8(output bit seen, output int lat, output int busy_cnt);
    seen = 1'b0; lat = 0;
    busy_cnt = busy8 ? 1 : 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
      else if (busy8) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    s16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q8, r8, busy8, done8, dbz8, ovf8} !== 20'h0) begin
      failures++;
      $display("FAIL reset8: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
               q8, r8, busy8, done8, dbz8, ovf8);
    end
    checks++;
    if ({q16, r16, busy16, done16, dbz16, ovf16} !== 36'h0) begin
      failures++;
      $display("FAIL reset16: got q=%h r=%h busy=%b done=%b, want all 0", q16, r16, busy16, done16);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    logic [7:0] ta [3] = '{8'd255, 8'd131, 8'd165};
    logic [7:0] tb [3] = '{8'd15, 8'd2, 8'd7};
    logic [7:0] tq [3] = '{8'd17, 8'd65, 8'd23};
    logic [7:0] tr [3] = '{8'd0, 8'd1, 8'd4};
    bit seen; int lat; int bc; exp8_t e;
    for (int i = 0; i < 3; i++) begin
      issue8(1'b0, ta[i], tb[i], tq[i], tr[i], 1'b0, 1'b0);
      wait8(seen, lat, bc);
      e = sb8.pop_front();
      $display("txn unsigned %0d/%0d -> q=%0d r=%0d lat=%0d", ta[i], tb[i], q8, r8, lat);
      checks++;
      if (!seen || {q8, r8, dbz8, ovf8} !== {e.q, e.r, e.dbz, e.ovf}) begin
        failures++;
        $display("FAIL unsigned_result: got q=%0d r=%0d dbz=%b ovf=%b done=%b, want q=%0d r=%0d flags 0",
                 q8, r8, dbz8, ovf8, seen, e.q, e.r);
      end
      checks++;
      if (lat != 9 || bc != 9) begin
        failures++;
        $display("FAIL unsigned_latency: got lat=%0d busy=%0d, want 9 and 9", lat, bc);
      end
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse: Done=%b one cycle after pulse, want 0", done8);
      end
    end
  endtask

  task automatic test_signed;
    logic [7:0] ta [2] = '{8'hF9, 8'h07};
    logic [7:0] tb [2] = '{8'h02, 8'hFE};
    logic [7:0] tq [2] = '{8'hFD, 8'hFD};
    logic [7:0] tr [2] = '{8'hFF, 8'h01};
    bit seen; int lat; int bc; exp8_t e;
    for (int i = 0; i < 2; i++) begin
      issue8(1'b1, ta[i], tb[i], tq[i], tr[i], 1'b0, 1'b0);
      wait8(seen, lat, bc);
      e = sb8.pop_front();
      $display("txn signed %h/%h -> q=%h r=%h lat=%0d", ta[i], tb[i], q8, r8, lat);
      checks++;
      if (!seen || lat != 9 || {q8, r8, dbz8, ovf8} !== {e.q, e.r, e.dbz, e.ovf}) begin
        failures++;
        $display("FAIL signed_result: got q=%h r=%h flags=%b%b lat=%0d, want q=%h r=%h flags 00 lat 9",
                 q8, r8, dbz8, ovf8, lat, e.q, e.r);
      end
    end
  endtask

  task automatic test_flags;
    logic       tsm [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ta [3] = '{8'h55, 8'h80, 8'd100};
    logic [7:0] tb [3] = '{8'h00, 8'hFF, 8'd10};
    logic [7:0] tq [3] = '{8'hFF, 8'h80, 8'd10};
    logic [7:0] tr [3] = '{8'h55, 8'h00, 8'd0};
    logic       tz [3] = '{1'b1, 1'b0, 1'b0};
    logic       tv [3] = '{1'b0, 1'b1, 1'b0};
    int         tl [3] = '{1, 9, 9};
    bit seen; int lat; int bc; exp8_t e;
    for (int i = 0; i < 3; i++) begin
      issue8(tsm[i], ta[i], tb[i], tq[i], tr[i], tz[i], tv[i]);
      wait8(seen, lat, bc);
      e = sb8.pop_front();
      $display("txn flags %h/%h -> q=%h r=%h dbz=%b ovf=%b lat=%0d", ta[i], tb[i], q8, r8, dbz8, ovf8, lat);
      checks++;
      if (!seen || {q8, r8, dbz8, ovf8} !== {e.q, e.r, e.dbz, e.ovf}) begin
        failures++;
        $display("FAIL flags_result: got q=%h r=%h dbz=%b ovf=%b, want q=%h r=%h dbz=%b ovf=%b",
                 q8, r8, dbz8, ovf8, e.q, e.r, e.dbz, e.ovf);
      end
      checks++;
      if (lat != tl[i]) begin
        failures++;
        $display("FAIL flags_latency: got %0d, want %0d", lat, tl[i]);
      end
    end
  endtask

  task automatic test_handshake;
    bit seen; int lat; int bc; int extra; exp8_t e;
    issue8(1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    s8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
    @(posedge clk); #1;
    s8 = 1'b0;
    wait8(seen, lat, bc);
    e = sb8.pop_front();
    $display("txn busy-start 100/7 -> q=%0d r=%0d", q8, r8);
    checks++;
    if (!seen || {q8, r8} !== {e.q, e.r}) begin
      failures++;
      $display("FAIL ignore_start: got q=%0d r=%0d done=%b, want q=%0d r=%0d", q8, r8, seen, e.q, e.r);
    end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_start_extra: got %0d extra Done pulses, want 0", extra);
    end

    issue8(1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0);
    void'(sb8.pop_back());
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    checks++;
    if ({q8, r8, busy8, done8, dbz8, ovf8} !== 20'h0) begin
      failures++;
      $display("FAIL reset_abort: got q=%h r=%h busy=%b done=%b, want all 0", q8, r8, busy8, done8);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b done=%b after release, want 0 0", busy8, done8);
    end
    issue8(1'b0, 8'd252, 8'd7, 8'd36, 8'd0, 1'b0, 1'b0);
    wait8(seen, lat, bc);
    e = sb8.pop_front();
    $display("txn post-reset 252/7 -> q=%0d r=%0d lat=%0d", q8, r8, lat);
    checks++;
    if (!seen || lat != 9 || {q8, r8} !== {e.q, e.r}) begin
      failures++;
      $display("FAIL post_reset: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat 9", q8, r8, lat, e.q, e.r);
    end
  endtask

  // Back-to-back random operations, checked against SV's own truncating division.
  task automatic test_back_to_back;
    bit seen; int lat; int bc; exp8_t e;
    logic sm; logic [7:0] a, b, eq, er;
    int sa, sbv, mq, mr;
    for (int i = 0; i < 16; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 255));
      b  = 8'($urandom_range(1, 255));
      if (sm && a == 8'h80 && b == 8'hFF) b = 8'h03;
      if (sm) begin sa = $signed(a); sbv = $signed(b); end
      else begin sa = int'(a); sbv = int'(b); end
      mq = sa / sbv; mr = sa % sbv;
      eq = mq[7:0]; er = mr[7:0];
      issue8(sm, a, b, eq, er, 1'b0, 1'b0);
      wait8(seen, lat, bc);
      e = sb8.pop_front();
      $display("txn b2b mode=%b %h/%h -> q=%h r=%h lat=%0d", sm, a, b, q8, r8, lat);
      checks++;
      if (!seen || lat != 9 || {q8, r8, dbz8, ovf8} !== {e.q, e.r, e.dbz, e.ovf}) begin
        failures++;
        $display("FAIL b2b: mode=%b %h/%h got q=%h r=%h lat=%0d, want q=%h r=%h lat 9",
                 sm, a, b, q8, r8, lat, e.q, e.r);
      end
    end
  endtask

  task automatic test_width16;
    logic        tsm [2] = '{1'b0, 1'b1};
    logic [15:0] ta [2] = '{16'd65535, 16'hFFF9};
    logic [15:0] tb [2] = '{16'd255, 16'd2};
    logic [15:0] tq [2] = '{16'd257, 16'd32764};
    logic [15:0] tr [2] = '{16'd0, 16'd1};
    exp16_t e; bit seen; int lat;
    for (int i = 0; i < 2; i++) begin
      e.q = tq[i]; e.r = tr[i];
      sb16.push_back(e);
      s16 = 1'b1; sm16 = tsm[i]; a16 = ta[i]; b16 = tb[i];
      @(posedge clk); #1;
      s16 = 1'b0;
      seen = 1'b0; lat = 0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(posedge clk); #1;
        lat++;
        if (done16) seen = 1'b1;
      end
      e = sb16.pop_front();
      $display("txn w16 mode=%b %0d/%0d -> q=%0d r=%0d lat=%0d", tsm[i], ta[i], tb[i], q16, r16, lat);
      checks++;
      if (!seen || {q16, r16, dbz16, ovf16} !== {e.q, e.r, 2'b00}) begin
        failures++;
        $display("FAIL w16_result: got q=%0d r=%0d dbz=%b ovf=%b, want q=%0d r=%0d flags 0",
                 q16, r16, dbz16, ovf16, e.q, e.r);
      end
      checks++;
      if (lat != 17) begin
        failures++;
        $display("FAIL w16_latency: got %0d, want 17", lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_flags;
    test_handshake;
    test_back_to_back;
    test_width16;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
